// File: rtl/reg_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_wb_pkg
// Purpose  : Shared widths and entry type for the register write-back front end
// Revision : 1.0
// ============================================================================
package reg_wb_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;

  localparam logic [ADDR_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/reg_writeback_if.sv
`default_nettype none
// ============================================================================
// Module   : reg_writeback_if
// Purpose  : Producer handshakes and register-file write port (REG_WB_FWD_EN adds lookup)
// Revision : 1.0
// ============================================================================
interface reg_writeback_if #(
  parameter int DEPTH = 4
) ();
  import reg_wb_pkg::*;

  localparam int CW = $clog2(DEPTH + 1);

  logic              mem_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              wb_stall;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              wb_load;
  logic [CW-1:0]     pending;
`ifdef REG_WB_FWD_EN
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic              fwd_hit_a;
  logic              fwd_hit_b;
  logic [DATA_W-1:0] fwd_data_a;
  logic [DATA_W-1:0] fwd_data_b;
`endif

  modport master (
    output mem_valid, mem_addr, mem_data, alu_valid, alu_addr, alu_data, wb_stall,
    input  mem_ready, alu_ready, wb_addr, wb_data, wb_load, pending
`ifdef REG_WB_FWD_EN
    , output rd_addr_a, rd_addr_b,
    input  fwd_hit_a, fwd_hit_b, fwd_data_a, fwd_data_b
`endif
  );

  modport slave (
    input  mem_valid, mem_addr, mem_data, alu_valid, alu_addr, alu_data, wb_stall,
    output mem_ready, alu_ready, wb_addr, wb_data, wb_load, pending
`ifdef REG_WB_FWD_EN
    , input rd_addr_a, rd_addr_b,
    output fwd_hit_a, fwd_hit_b, fwd_data_a, fwd_data_b
`endif
  );

endinterface
`default_nettype wire

// File: rtl/reg_writeback_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_fifo
// Purpose  : In-order queue with two ordered write ports, one pop port, visible storage
// Revision : 1.0
// ============================================================================
module wb_fifo
  import reg_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr0_en,
  input  wb_entry_t                    wr0_entry,
  input  logic                         wr1_en,
  input  wb_entry_t                    wr1_entry,
  input  logic                         pop,
  output wb_entry_t                    entries [DEPTH],
  output logic [$clog2(DEPTH)-1:0]     rptr,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  wb_entry_t     r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [PW-1:0] w_wr1_ptr;

  // Port 1 lands behind port 0 when both write, keeping port 0 older.
  assign w_wr1_ptr = wr0_en ? PW'(r_wptr + PW'(1)) : r_wptr;

  always_ff @(posedge clk) begin
    if (wr0_en) r_mem[r_wptr]    <= wr0_entry;
    if (wr1_en) r_mem[w_wr1_ptr] <= wr1_entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_wptr  <= r_wptr + PW'(wr0_en) + PW'(wr1_en);
      r_rptr  <= r_rptr + PW'(pop);
      r_count <= r_count + CW'(wr0_en) + CW'(wr1_en) - CW'(pop);
    end
  end

  assign entries = r_mem;
  assign rptr    = r_rptr;
  assign count   = r_count;

endmodule
`default_nettype wire

// File: rtl/reg_writeback.sv
`default_nettype none
// ============================================================================
// Module   : reg_writeback
// Purpose  : Merges ALU/load write-backs into an ordered queue draining to the regfile
//            (REG_WB_FWD_EN adds a two-port forwarding lookup)
// Revision : 1.0
// ============================================================================
module reg_writeback
  import reg_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  reg_writeback_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  wb_entry_t         w_entries [DEPTH];
  wb_entry_t         w_head;
  logic [PW-1:0]     w_rptr;
  logic [CW-1:0]     w_count;
  logic [CW-1:0]     w_free;
  logic              w_mem_acc;
  logic              w_alu_acc;
  logic              w_pop;
  logic              r_wb_load;
  logic [ADDR_W-1:0] r_wb_addr;
  logic [DATA_W-1:0] r_wb_data;

  // Space is judged on registered occupancy only; a same-cycle pop frees nothing.
  assign w_free        = CW'(DEPTH) - w_count;
  assign bus.mem_ready = (w_free >= CW'(1));
  assign bus.alu_ready = bus.mem_valid ? (w_free >= CW'(2)) : (w_free >= CW'(1));

  assign w_mem_acc = bus.mem_valid & bus.mem_ready;
  assign w_alu_acc = bus.alu_valid & bus.alu_ready;
  assign w_pop     = (w_count != '0) & ~bus.wb_stall;
  assign w_head    = w_entries[w_rptr];

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr0_en    (w_mem_acc),
    .wr0_entry ({bus.mem_addr, bus.mem_data}),
    .wr1_en    (w_alu_acc),
    .wr1_entry ({bus.alu_addr, bus.alu_data}),
    .pop       (w_pop),
    .entries   (w_entries),
    .rptr      (w_rptr),
    .count     (w_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_load <= 1'b0;
      r_wb_addr <= '0;
      r_wb_data <= '0;
    end else if (w_pop) begin
      r_wb_load <= (w_head.addr != ZERO_REG);
      r_wb_addr <= w_head.addr;
      r_wb_data <= w_head.data;
    end else begin
      r_wb_load <= 1'b0;
    end
  end

  assign bus.wb_load = r_wb_load;
  assign bus.wb_addr = r_wb_addr;
  assign bus.wb_data = r_wb_data;
  assign bus.pending = w_count;

`ifdef REG_WB_FWD_EN
  logic              w_hit_a;
  logic              w_hit_b;
  logic [DATA_W-1:0] w_fwd_a;
  logic [DATA_W-1:0] w_fwd_b;

  // Scan oldest to youngest so the last match wins; the write port stage is oldest.
  always_comb begin
    w_hit_a = 1'b0;
    w_hit_b = 1'b0;
    w_fwd_a = '0;
    w_fwd_b = '0;
    if (r_wb_load && r_wb_addr == bus.rd_addr_a) begin
      w_hit_a = 1'b1;
      w_fwd_a = r_wb_data;
    end
    if (r_wb_load && r_wb_addr == bus.rd_addr_b) begin
      w_hit_b = 1'b1;
      w_fwd_b = r_wb_data;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < w_count) begin
        if (w_entries[PW'(w_rptr + PW'(i))].addr == bus.rd_addr_a) begin
          w_hit_a = 1'b1;
          w_fwd_a = w_entries[PW'(w_rptr + PW'(i))].data;
        end
        if (w_entries[PW'(w_rptr + PW'(i))].addr == bus.rd_addr_b) begin
          w_hit_b = 1'b1;
          w_fwd_b = w_entries[PW'(w_rptr + PW'(i))].data;
        end
      end
    end
    if (bus.rd_addr_a == ZERO_REG) begin
      w_hit_a = 1'b0;
      w_fwd_a = '0;
    end
    if (bus.rd_addr_b == ZERO_REG) begin
      w_hit_b = 1'b0;
      w_fwd_b = '0;
    end
  end

  assign bus.fwd_hit_a  = w_hit_a;
  assign bus.fwd_hit_b  = w_hit_b;
  assign bus.fwd_data_a = w_fwd_a;
  assign bus.fwd_data_b = w_fwd_b;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_writeback.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_writeback
// Purpose  : Directed self-checking bench for reg_writeback
// Revision : 1.0
// ============================================================================
module tb_reg_writeback;
  import reg_wb_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  reg_writeback_if #(.DEPTH(DEPTH)) bus ();

  reg_writeback #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    tests++; if (bus.pending !== 3'd0) begin fails++; $display("FAIL reset_pending: got %0d want 0", bus.pending); end
    tests++; if (bus.wb_load !== 1'b0) begin fails++; $display("FAIL reset_wb_load: got %b want 0", bus.wb_load); end
    tests++; if (bus.wb_addr !== 4'd0) begin fails++; $display("FAIL reset_wb_addr: got %h want 0", bus.wb_addr); end
    tests++; if (bus.wb_data !== 16'h0000) begin fails++; $display("FAIL reset_wb_data: got %h want 0000", bus.wb_data); end
    tests++; if (bus.mem_ready !== 1'b1) begin fails++; $display("FAIL reset_mem_ready: got %b want 1", bus.mem_ready); end
    tests++; if (bus.alu_ready !== 1'b1) begin fails++; $display("FAIL reset_alu_ready: got %b want 1", bus.alu_ready); end
  endtask

  task automatic test_single;
    bus.mem_valid = 1'b1; bus.mem_addr = 4'd3; bus.mem_data = 16'h00AA;
    #1;
    tests++; if (bus.mem_ready !== 1'b1) begin fails++; $display("FAIL single_mem_ready: got %b want 1", bus.mem_ready); end
    tick;
    bus.mem_valid = 1'b0;
    tests++; if (bus.pending !== 3'd1 || bus.wb_load !== 1'b0) begin fails++; $display("FAIL single_edge_k: pending %0d load %b want 1 0", bus.pending, bus.wb_load); end
    tick;
    tests++; if (bus.wb_load !== 1'b1 || bus.wb_addr !== 4'd3 || bus.wb_data !== 16'h00AA) begin fails++; $display("FAIL single_out: load %b addr %h data %h want 1 3 00aa", bus.wb_load, bus.wb_addr, bus.wb_data); end
    tests++; if (bus.pending !== 3'd0) begin fails++; $display("FAIL single_pending: got %0d want 0", bus.pending); end
    tick;
    tests++; if (bus.wb_load !== 1'b0 || bus.wb_data !== 16'h00AA) begin fails++; $display("FAIL single_hold: load %b data %h want 0 00aa", bus.wb_load, bus.wb_data); end
  endtask

  task automatic test_dual;
    bus.mem_valid = 1'b1; bus.mem_addr = 4'd5; bus.mem_data = 16'h1111;
    bus.alu_valid = 1'b1; bus.alu_addr = 4'd5; bus.alu_data = 16'h2222;
    #1;
    tests++; if (bus.alu_ready !== 1'b1) begin fails++; $display("FAIL dual_alu_ready: got %b want 1", bus.alu_ready); end
    tick;
    bus.mem_valid = 1'b0; bus.alu_valid = 1'b0;
    tests++; if (bus.pending !== 3'd2) begin fails++; $display("FAIL dual_pending: got %0d want 2", bus.pending); end
    tick;
    tests++; if (bus.wb_load !== 1'b1 || bus.wb_addr !== 4'd5 || bus.wb_data !== 16'h1111) begin fails++; $display("FAIL dual_first: load %b addr %h data %h want 1 5 1111", bus.wb_load, bus.wb_addr, bus.wb_data); end
    tick;
    tests++; if (bus.wb_load !== 1'b1 || bus.wb_addr !== 4'd5 || bus.wb_data !== 16'h2222) begin fails++; $display("FAIL dual_second: load %b addr %h data %h want 1 5 2222", bus.wb_load, bus.wb_addr, bus.wb_data); end
    tick;
    tests++; if (bus.wb_load !== 1'b0 || bus.pending !== 3'd0) begin fails++; $display("FAIL dual_idle: load %b pending %0d want 0 0", bus.wb_load, bus.pending); end
  endtask

  task automatic test_stall_full;
    bus.wb_stall = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus.alu_valid = 1'b1; bus.alu_addr = 4'(i); bus.alu_data = {12'h0A0, 4'(i)};
      if (i == 4) begin
        bus.mem_valid = 1'b1;
        #1;
        tests++; if (bus.alu_ready !== 1'b0 || bus.mem_ready !== 1'b1) begin fails++; $display("FAIL one_free_ready: alu %b mem %b want 0 1", bus.alu_ready, bus.mem_ready); end
        bus.mem_valid = 1'b0;
        #1;
        tests++; if (bus.alu_ready !== 1'b1) begin fails++; $display("FAIL one_free_alu_alone: got %b want 1", bus.alu_ready); end
      end
      tick;
    end
    bus.alu_valid = 1'b0;
    tests++; if (bus.pending !== 3'd4) begin fails++; $display("FAIL full_pending: got %0d want 4", bus.pending); end
    tests++; if (bus.alu_ready !== 1'b0 || bus.mem_ready !== 1'b0) begin fails++; $display("FAIL full_ready: alu %b mem %b want 0 0", bus.alu_ready, bus.mem_ready); end
    tick;
    tests++; if (bus.wb_load !== 1'b0 || bus.pending !== 3'd4) begin fails++; $display("FAIL stall_hold: load %b pending %0d want 0 4", bus.wb_load, bus.pending); end
    bus.wb_stall = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick;
      tests++; if (bus.wb_load !== 1'b1 || bus.wb_addr !== 4'(i) || bus.wb_data !== {12'h0A0, 4'(i)}) begin fails++; $display("FAIL drain_%0d: load %b addr %h data %h want 1 %h 0a0%h", i, bus.wb_load, bus.wb_addr, bus.wb_data, i, i); end
    end
    tick;
    tests++; if (bus.wb_load !== 1'b0 || bus.pending !== 3'd0) begin fails++; $display("FAIL drain_end: load %b pending %0d want 0 0", bus.wb_load, bus.pending); end
  endtask

  task automatic test_zero_reg;
    bus.alu_valid = 1'b1; bus.alu_addr = 4'd0; bus.alu_data = 16'hFFFF;
    tick;
    bus.alu_valid = 1'b0;
    tests++; if (bus.pending !== 3'd1) begin fails++; $display("FAIL zero_accept: pending %0d want 1", bus.pending); end
    tick;
    tests++; if (bus.wb_load !== 1'b0 || bus.wb_addr !== 4'd0 || bus.wb_data !== 16'hFFFF) begin fails++; $display("FAIL zero_pop: load %b addr %h data %h want 0 0 ffff", bus.wb_load, bus.wb_addr, bus.wb_data); end
    tests++; if (bus.pending !== 3'd0) begin fails++; $display("FAIL zero_pending: got %0d want 0", bus.pending); end
  endtask

  task automatic test_reset_mid;
    bus.mem_valid = 1'b1; bus.mem_addr = 4'd1; bus.mem_data = 16'h0011;
    bus.alu_valid = 1'b1; bus.alu_addr = 4'd2; bus.alu_data = 16'h0022;
    tick;
    bus.mem_addr = 4'd3; bus.mem_data = 16'h0033;
    bus.alu_addr = 4'd4; bus.alu_data = 16'h0044;
    #1;
    tests++; if (bus.alu_ready !== 1'b1) begin fails++; $display("FAIL two_free_alu_ready: got %b want 1", bus.alu_ready); end
    tick;
    bus.mem_valid = 1'b0; bus.alu_valid = 1'b0;
    tests++; if (bus.pending !== 3'd3 || bus.wb_load !== 1'b1 || bus.wb_addr !== 4'd1) begin fails++; $display("FAIL overlap: pending %0d load %b addr %h want 3 1 1", bus.pending, bus.wb_load, bus.wb_addr); end
    rst = 1'b1;
    #1;
    tests++; if (bus.wb_load !== 1'b0 || bus.pending !== 3'd0 || bus.wb_addr !== 4'd0) begin fails++; $display("FAIL async_reset: load %b pending %0d addr %h want 0 0 0", bus.wb_load, bus.pending, bus.wb_addr); end
    tick;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      tests++; if (bus.wb_load !== 1'b0 || bus.pending !== 3'd0) begin fails++; $display("FAIL post_reset_%0d: load %b pending %0d want 0 0", i, bus.wb_load, bus.pending); end
    end
  endtask

`ifdef REG_WB_FWD_EN
  task automatic test_forwarding;
    bus.wb_stall = 1'b1;
    bus.alu_valid = 1'b1; bus.alu_addr = 4'd7; bus.alu_data = 16'h0001;
    tick;
    bus.alu_data = 16'h0002;
    tick;
    bus.alu_valid = 1'b0;
    bus.rd_addr_a = 4'd7; bus.rd_addr_b = 4'd0;
    #1;
    tests++; if (bus.fwd_hit_a !== 1'b1 || bus.fwd_data_a !== 16'h0002) begin fails++; $display("FAIL fwd_youngest: hit %b data %h want 1 0002", bus.fwd_hit_a, bus.fwd_data_a); end
    tests++; if (bus.fwd_hit_b !== 1'b0) begin fails++; $display("FAIL fwd_zero: hit %b want 0", bus.fwd_hit_b); end
    bus.rd_addr_b = 4'd9;
    #1;
    tests++; if (bus.fwd_hit_b !== 1'b0) begin fails++; $display("FAIL fwd_miss: hit %b want 0", bus.fwd_hit_b); end
    bus.wb_stall = 1'b0;
    tick;
    tick;
    tests++; if (bus.fwd_hit_a !== 1'b1 || bus.fwd_data_a !== 16'h0002 || bus.pending !== 3'd0) begin fails++; $display("FAIL fwd_wb_stage: hit %b data %h pending %0d want 1 0002 0", bus.fwd_hit_a, bus.fwd_data_a, bus.pending); end
    tick;
    tests++; if (bus.fwd_hit_a !== 1'b0) begin fails++; $display("FAIL fwd_gone: hit %b want 0", bus.fwd_hit_a); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    bus.mem_valid = 1'b0; bus.mem_addr = '0; bus.mem_data = '0;
    bus.alu_valid = 1'b0; bus.alu_addr = '0; bus.alu_data = '0;
    bus.wb_stall  = 1'b0;
`ifdef REG_WB_FWD_EN
    bus.rd_addr_a = '0; bus.rd_addr_b = '0;
`endif
    tick;
    test_reset;
    tick;
    rst = 1'b0;
    tick;
    test_single;
    test_dual;
    test_stall_full;
    test_zero_reg;
    test_reset_mid;
`ifdef REG_WB_FWD_EN
    test_forwarding;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
